// File: rtl/rx_frame_parser_pkg.sv
// Shared types and constants for the UART receive-frame parser.
package rx_frame_pkg;

  // Parser states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_END     = 3'd4
  } rx_state_t;

  // Rejection reasons reported on err_code
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_CMD  = 3'd1,
    ERR_NO_SIZE  = 3'd2,
    ERR_BAD_LEN  = 3'd3,
    ERR_BAD_SIZE = 3'd4,
    ERR_BAD_EOF  = 3'd5,
    ERR_TIMEOUT  = 3'd6
  } rx_err_t;

  localparam logic [7:0] SOF = 8'hFE;
  localparam logic [7:0] EOF = 8'hEF;

  localparam logic [7:0] CMD_SIZE   = 8'h01;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_MATRIX = 8'h03;
  localparam logic [7:0] CMD_VECTOR = 8'h04;

endpackage

// File: rtl/rx_frame_parser_if.sv
// Byte-in / RAM-write-out bundle of the frame parser.
// master: UART side + consumers of the parser results; slave: the parser.
interface rx_frame_parser_if #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 8,
  parameter int ADDR_W = $clog2(MAX_N * MAX_N)
);
  localparam int NW = $clog2(MAX_N + 1);

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [NW-1:0]     size_n;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start_pulse;
  logic              frame_ok;
  logic              frame_err;
  logic [2:0]        err_code;

  modport master (
    output rx_valid, rx_data,
    input  size_n, wr_en, wr_sel, wr_addr, wr_data,
    input  start_pulse, frame_ok, frame_err, err_code
  );

  modport slave (
    input  rx_valid, rx_data,
    output size_n, wr_en, wr_sel, wr_addr, wr_data,
    output start_pulse, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/rx_frame_parser_payload_counter.sv
// Payload byte counter: holds the write index, the expected payload count
// latched at CMD time, and flags the last payload byte.
module rx_payload_counter #(
  parameter int CW     = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [CW-1:0]     count_i,
  input  logic              inc_i,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] count_q;

  // Index and expected-count registers; clear wins, load restarts at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
    end else if (load_i) begin
      cnt_q   <= '0;
      count_q <= count_i;
    end else if (inc_i) begin
      cnt_q   <= cnt_q + CW'(1'b1);
    end
  end

  // Compare at full width: N*N is never truncated before this check
  assign last_o = (count_q != '0) && (cnt_q == (count_q - CW'(1'b1)));
  assign cnt_o  = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/rx_frame_parser.sv
// UART receive-frame parser: FE LEN CMD payload EF -> RAM writes, size
// commit, start request, and error reporting.
// Optional feature: define RX_TIMEOUT_EN to abort frames that stall for
// TIMEOUT_CYCLES clocks between bytes.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int MAX_N          = 8,
  parameter int ADDR_W         = $clog2(MAX_N * MAX_N),
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               reset,
  rx_frame_parser_if.slave  bus
);

  localparam int NW = $clog2(MAX_N + 1);
  localparam int CW = 2 * NW;

  rx_state_t         state_q, state_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [NW-1:0]     pending_q, pending_d;
  logic [NW-1:0]     size_n_q, size_n_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;
  rx_err_t           err_code_q, err_code_d;

  logic              cnt_load_s, cnt_inc_s, cnt_clear_s, cnt_last_s;
  logic [ADDR_W-1:0] cnt_s;
  logic [CW-1:0]     exp_cnt_s;
  logic [CW:0]       need_len_s;
  logic              timeout_s;
  logic              fail_s;
  rx_err_t           fail_code_s;

  rx_payload_counter #(.CW(CW), .ADDR_W(ADDR_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (cnt_load_s),
    .count_i (exp_cnt_s),
    .inc_i   (cnt_inc_s),
    .clear_i (cnt_clear_s),
    .cnt_o   (cnt_s),
    .last_o  (cnt_last_s)
  );

`ifdef RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_q;

  // Inter-byte idle counter; only runs while a frame is in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else if ((state_q == ST_IDLE) || bus.rx_valid || timeout_s) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1'b1);
    end
  end

  assign timeout_s = (state_q != ST_IDLE) && !bus.rx_valid &&
                     (idle_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Expected payload count from the committed size; drives the CMD checks
  always_comb begin
    exp_cnt_s = '0;
    case (bus.rx_data)
      DATA_W'(CMD_SIZE):   exp_cnt_s = CW'(1'b1);
      DATA_W'(CMD_START):  exp_cnt_s = '0;
      DATA_W'(CMD_MATRIX): exp_cnt_s = CW'(size_n_q) * CW'(size_n_q);
      DATA_W'(CMD_VECTOR): exp_cnt_s = CW'(size_n_q);
      default:             exp_cnt_s = '0;
    endcase
    need_len_s = {1'b0, exp_cnt_s} + (CW+1)'(1'b1);
  end

  // Next-state and registered-output decode of the frame FSM
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cmd_d       = cmd_q;
    pending_d   = pending_q;
    size_n_d    = size_n_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    cnt_clear_s = 1'b0;
    fail_s      = 1'b0;
    fail_code_s = ERR_NONE;

    if (timeout_s) begin
      fail_s      = 1'b1;
      fail_code_s = ERR_TIMEOUT;
    end else if (bus.rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == DATA_W'(SOF)) begin
            state_d = ST_LEN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEN: begin
          len_d   = bus.rx_data;
          state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d = bus.rx_data;
          if ((bus.rx_data != DATA_W'(CMD_SIZE))   && (bus.rx_data != DATA_W'(CMD_START)) &&
              (bus.rx_data != DATA_W'(CMD_MATRIX)) && (bus.rx_data != DATA_W'(CMD_VECTOR))) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_BAD_CMD;
          end else if (((bus.rx_data == DATA_W'(CMD_MATRIX)) ||
                        (bus.rx_data == DATA_W'(CMD_VECTOR))) && (size_n_q == '0)) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_NO_SIZE;
          end else if (32'(len_q) != 32'(need_len_s)) begin
            fail_s      = 1'b1;
            fail_code_s = ERR_BAD_LEN;
          end else if (bus.rx_data == DATA_W'(CMD_START)) begin
            state_d = ST_END;
          end else begin
            wr_sel_d   = (bus.rx_data == DATA_W'(CMD_VECTOR));
            cnt_load_s = 1'b1;
            state_d    = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (cmd_q == DATA_W'(CMD_SIZE)) begin
            if ((bus.rx_data == '0) || (32'(bus.rx_data) > 32'(MAX_N))) begin
              fail_s      = 1'b1;
              fail_code_s = ERR_BAD_SIZE;
            end else begin
              pending_d = NW'(bus.rx_data);
              state_d   = ST_END;
            end
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.rx_data;
            wr_addr_d = cnt_s;
            if (cnt_last_s) begin
              cnt_clear_s = 1'b1;
              state_d     = ST_END;
            end else begin
              cnt_inc_s = 1'b1;
            end
          end
        end
        ST_END: begin
          if (bus.rx_data == DATA_W'(EOF)) begin
            ok_d    = 1'b1;
            state_d = ST_IDLE;
            if (cmd_q == DATA_W'(CMD_SIZE)) begin
              size_n_d = pending_q;
            end else begin
              size_n_d = size_n_q;
            end
            if (cmd_q == DATA_W'(CMD_START)) begin
              start_d = 1'b1;
            end else begin
              start_d = 1'b0;
            end
          end else begin
            fail_s      = 1'b1;
            fail_code_s = ERR_BAD_EOF;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end

    if (fail_s) begin
      err_d       = 1'b1;
      err_code_d  = fail_code_s;
      cnt_clear_s = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      err_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cmd_q      <= '0;
      pending_q  <= '0;
      size_n_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      pending_q  <= pending_d;
      size_n_q   <= size_n_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.size_n      = size_n_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_sel      = wr_sel_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.start_pulse = start_q;
  assign bus.frame_ok    = ok_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed testbench for rx_frame_parser (MAX_N=8, TIMEOUT_CYCLES=16).
// The timeout section is active when RX_TIMEOUT_EN is defined.
module tb_rx_frame_parser;

  logic clk;
  logic reset;

  rx_frame_parser_if #(.DATA_W(8), .MAX_N(8)) bus ();

  rx_frame_parser #(
    .DATA_W(8), .MAX_N(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sel;
    logic [5:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wrq[$];
  int         ok_cnt, err_cnt, start_cnt;
  int         n_checks, n_errors;
  logic [7:0] frm[$];
  logic       last_ok, last_err, last_start;
  logic [2:0] last_code;

  // Record every write and pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_en) wrq.push_back({bus.wr_sel, bus.wr_addr, bus.wr_data});
      if (bus.frame_ok) ok_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.start_pulse) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte strobe; outputs are captured 1 ns after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    last_ok    = bus.frame_ok;
    last_err   = bus.frame_err;
    last_start = bus.start_pulse;
    last_code  = bus.err_code;
  endtask

  // Send frm back-to-back and start fresh counters
  task automatic send_frm();
    wrq.delete();
    ok_cnt = 0; err_cnt = 0; start_cnt = 0;
    foreach (frm[i]) send_byte(frm[i]);
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    ok_cnt = 0; err_cnt = 0; start_cnt = 0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_size_n", 32'(bus.size_n), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_ok_err", 32'({bus.frame_ok, bus.frame_err, bus.start_pulse}), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Matrix before any size is configured
    frm = '{8'hFE, 8'h05, 8'h03};
    send_frm();
    check("nosize_code", 32'(bus.err_code), 32'd2);
    check("nosize_err", 32'(err_cnt), 32'd1);
    check("nosize_nowr", 32'(wrq.size()), 32'd0);

    // N=3 setup
    frm = '{8'hFE, 8'h02, 8'h01, 8'h03, 8'hEF};
    send_frm();
    check("n3_ok", 32'(ok_cnt), 32'd1);
    check("n3_size", 32'(bus.size_n), 32'd3);
    check("n3_nowr", 32'(wrq.size()), 32'd0);
    check("n3_code_held", 32'(bus.err_code), 32'd2);

    // Vector load with N=3
    frm = '{8'hFE, 8'h04, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'hEF};
    send_frm();
    check("vec_cnt", 32'(wrq.size()), 32'd3);
    if (wrq.size() == 3) begin
      check("vec_w0", 32'(wrq[0]), 32'({1'b1, 6'd0, 8'h0A}));
      check("vec_w1", 32'(wrq[1]), 32'({1'b1, 6'd1, 8'h0B}));
      check("vec_w2", 32'(wrq[2]), 32'({1'b1, 6'd2, 8'h0C}));
    end else begin
      check("vec_wr_present", 32'd0, 32'd1);
    end
    check("vec_ok", 32'(ok_cnt), 32'd1);

    // Size out of range: error on the size byte, EOF then discarded
    wrq.delete(); ok_cnt = 0; err_cnt = 0;
    frm = '{8'hFE, 8'h02, 8'h01};
    foreach (frm[i]) send_byte(frm[i]);
    send_byte(8'h09);
    check("size9_err", 32'({last_err, last_code}), 32'({1'b1, 3'd4}));
    send_byte(8'hEF);
    check("size9_no_ok", 32'(last_ok), 32'd0);
    check("size9_keep_n", 32'(bus.size_n), 32'd3);

    // Matrix load with N=2, back-to-back
    frm = '{8'hFE, 8'h02, 8'h01, 8'h02, 8'hEF};
    send_frm();
    check("n2_size", 32'(bus.size_n), 32'd2);
    frm = '{8'hFE, 8'h05, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'hEF};
    send_frm();
    check("mat_cnt", 32'(wrq.size()), 32'd4);
    begin
      int bad;
      bad = 0;
      foreach (wrq[i]) if (wrq[i] != {1'b0, 6'(i), 8'(i + 1)}) bad++;
      check("mat_seq", 32'(bad), 32'd0);
    end
    check("mat_ok", 32'(ok_cnt), 32'd1);

    // Wrong LEN for a matrix with N=2 (needs 5)
    frm = '{8'hFE, 8'h03, 8'h03};
    send_frm();
    check("badlen", 32'({err_cnt[3:0], bus.err_code}), 32'({4'd1, 3'd3}));

    // Unknown command
    frm = '{8'hFE, 8'h01, 8'h07};
    send_frm();
    check("badcmd", 32'({err_cnt[3:0], bus.err_code}), 32'({4'd1, 3'd1}));

    // Wrong terminator on START
    frm = '{8'hFE, 8'h01, 8'h02, 8'h00};
    send_frm();
    check("badeof", 32'({err_cnt[3:0], bus.err_code}), 32'({4'd1, 3'd5}));
    check("badeof_nostart", 32'(start_cnt), 32'd0);

    // Valid START: start_pulse and frame_ok in the same cycle
    frm = '{8'hFE, 8'h01, 8'h02, 8'hEF};
    send_frm();
    check("start_same_cycle", 32'({last_ok, last_start}), 32'd3);

    // Payload bytes equal to SOF/EOF are plain data (N=2 vector)
    frm = '{8'hFE, 8'h03, 8'h04, 8'hFE, 8'hEF, 8'hEF};
    send_frm();
    check("esc_cnt", 32'(wrq.size()), 32'd2);
    if (wrq.size() == 2) begin
      check("esc_data", 32'({wrq[0].data, wrq[1].data}), 32'h0000FEEF);
    end else begin
      check("esc_wr_present", 32'd0, 32'd1);
    end
    check("esc_ok", 32'(ok_cnt), 32'd1);

    // Largest size: N=8 matrix, 64 bytes, LEN=0x41
    frm = '{8'hFE, 8'h02, 8'h01, 8'h08, 8'hEF};
    send_frm();
    check("n8_size", 32'(bus.size_n), 32'd8);
    frm = '{8'hFE, 8'h41, 8'h03};
    for (int i = 0; i < 64; i++) frm.push_back(8'(i + 16));
    frm.push_back(8'hEF);
    send_frm();
    check("m8_cnt", 32'(wrq.size()), 32'd64);
    begin
      int bad;
      bad = 0;
      foreach (wrq[i]) if (wrq[i] != {1'b0, 6'(i), 8'(i + 16)}) bad++;
      check("m8_seq", 32'(bad), 32'd0);
    end
    check("m8_ok", 32'(ok_cnt), 32'd1);

`ifdef RX_TIMEOUT_EN
    // Stall after LEN: error lands exactly 16 idle clocks later
    frm = '{8'hFE, 8'h02};
    wrq.delete(); ok_cnt = 0; err_cnt = 0; start_cnt = 0;
    foreach (frm[i]) send_byte(frm[i]);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_not_yet", 32'(bus.frame_err), 32'd0);
    @(posedge clk); #1;
    check("tmo_err", 32'({bus.frame_err, bus.err_code}), 32'({1'b1, 3'd6}));
    frm = '{8'hFE, 8'h01, 8'h02, 8'hEF};
    send_frm();
    check("tmo_restart", 32'({last_ok, last_start}), 32'd3);
`endif

    // Asynchronous reset in the middle of a matrix payload
    frm = '{8'hFE, 8'h41, 8'h03, 8'h55};
    ok_cnt = 0; err_cnt = 0;
    foreach (frm[i]) send_byte(frm[i]);
    check("pre_rst_wr", 32'(bus.wr_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_size", 32'(bus.size_n), 32'd0);
    check("arst_outs", 32'({bus.wr_en, bus.frame_err, bus.frame_ok}), 32'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    frm = '{8'hFE, 8'h01, 8'h02, 8'hEF};
    send_frm();
    check("arst_idle_after", 32'({err_cnt[3:0], last_ok, last_start}), 32'({4'd0, 2'd3}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_parser.md
# rx_frame_parser

Parametrised UART receive-frame parser for the matrix–vector product datapath. It sits between the UART receiver and the matrix/vector RAMs and controller. It decodes framed commands (start, length, command, payload, end) and streams payload bytes to RAM with computed addresses. It also validates frame length, size range and terminator, and reports errors instead of silently resynchronising.

## Interface
Parameters:
- DATA_W, 8, byte width of the UART data and RAM write data.
- MAX_N, 8, largest accepted matrix dimension N.
- ADDR_W, $clog2(MAX_N*MAX_N), RAM write address width.
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes inside a frame. Used only with RX_TIMEOUT_EN.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-low reset.
- rx_valid, in, 1, one-cycle strobe: rx_data holds a new byte.
- rx_data, in, DATA_W, received byte.
- size_n, out, $clog2(MAX_N+1), committed matrix dimension N; 0 means not configured.
- wr_en, out, 1, one-cycle RAM write strobe.
- wr_sel, out, 1, write target: 0 = matrix RAM, 1 = vector RAM.
- wr_addr, out, ADDR_W, write address. Matrix uses row-major index; vector uses element index.
- wr_data, out, DATA_W, write data.
- start_pulse, out, 1, one-cycle start-computation request.
- frame_ok, out, 1, one-cycle pulse: frame accepted.
- frame_err, out, 1, one-cycle pulse: frame rejected.
- err_code, out, 3, reason for the last rejection. Held until the next frame_err.

## Operation
- Frame bytes, in order: 0xFE, LEN, CMD, payload, 0xEF. LEN = 1 + payload byte count.
- Commands and payloads:
  - CMD 0x01 SIZE: payload 1 byte.
  - CMD 0x02 START: no payload.
  - CMD 0x03 MATRIX: N*N bytes.
  - CMD 0x04 VECTOR: N bytes.
- States: IDLE, LEN, CMD, PAYLOAD, END.
- IDLE: bytes other than 0xFE are discarded. 0xFE moves to LEN.
- LEN: the byte is latched into len_r. Move to CMD.
- CMD: check the command and LEN.
  - Unknown CMD goes to error, err_code 1.
  - MATRIX or VECTOR with size_n==0 goes to error, err_code 2.
  - len_r not equal to the expected 1+payload goes to error, err_code 3.
  - START goes to END. All other valid commands go to PAYLOAD.
- PAYLOAD:
  - SIZE: the byte goes to pending_n. A value of 0 or greater than MAX_N goes to error, err_code 4. Otherwise move to END.
  - MATRIX/VECTOR: each byte gives wr_en=1, wr_data=byte, wr_addr=cnt; cnt then increments. After the last byte (cnt==count-1), cnt clears and the state moves to END.
- END:
  - 0xEF gives frame_ok. SIZE commits size_n<=pending_n. START gives start_pulse.
  - Any other byte goes to error, err_code 5.
- Error: frame_err pulses, err_code is updated, cnt clears, state returns to IDLE.
- Committed effects on error:
  - size_n and start_pulse are committed only on a valid terminator.
  - RAM writes already issued are not rolled back. The controller must ignore RAM contents after frame_err.
- Payload bytes equal to 0xFE/0xEF are data, with no escaping.
- Expected count uses the committed size_n at CMD time. It is computed as N*N in 2*$clog2(MAX_N+1) bits, with no truncation before compare.

## Timing
- Every output is registered.
- Response appears on the clock edge after the rx_valid cycle: wr_en, frame_ok, frame_err and start_pulse are high for exactly the cycle following the byte's strobe.
- Reset values: state IDLE; size_n=0; wr_en=0, wr_sel=0, wr_addr=0, wr_data=0; start_pulse=0; frame_ok=0; frame_err=0; err_code=0; cnt=0.
- An asynchronous reset mid-frame aborts immediately. No frame_err is raised. size_n returns to 0.
- start_pulse and frame_ok assert in the same cycle.
- rx_valid back-to-back on consecutive clocks must be accepted with no byte lost.
- wr_sel is set at CMD and holds for the whole payload.

## Configuration
- RX_TIMEOUT_EN defined: an idle counter runs in every state except IDLE and clears on each rx_valid. When it reaches TIMEOUT_CYCLES-1 with no byte, the frame goes to error, err_code 6, and the state returns to IDLE.
- RX_TIMEOUT_EN undefined: there is no counter, and the parser waits indefinitely in any state.

## Structure
- Package rx_frame_pkg:
  - State enum rx_state_t.
  - Byte constants SOF=0xFE, EOF=0xEF.
  - CMD_SIZE/CMD_START/CMD_MATRIX/CMD_VECTOR.
  - err_code enum rx_err_t: 0 none, 1 bad_cmd, 2 no_size, 3 bad_len, 4 bad_size, 5 bad_eof, 6 timeout.
- Sub-module rx_payload_counter holds cnt, the expected-count compare and the last flag, with inputs load, inc and clear.

## Test plan
- N=3 setup: send FE 02 01 03 EF → next cycle frame_ok=1, size_n=3, no wr_en.
- Vector load with N=3: send FE 04 04 0A 0B 0C EF → three wr_en pulses, wr_sel=1, addr 0,1,2, data 0A,0B,0C, then frame_ok.
- Matrix load with N=2, all on back-to-back clocks: send FE 05 03 01 02 03 04 EF → wr_sel=0, addr 0..3 in order, frame_ok.
- Error cases:
  - Size out of range: FE 02 01 09 EF with MAX_N=8 → frame_err, err_code 4, size_n unchanged.
  - Wrong terminator: FE 01 02 00 → frame_err, err_code 5, no start_pulse.
  - Unconfigured size: MATRIX with size_n=0 → err_code 2.
- Timeout, with RX_TIMEOUT_EN and TIMEOUT_CYCLES=16: send FE 02 then idle 16 clocks → frame_err, err_code 6. A following FE 01 02 EF → start_pulse=1 and frame_ok=1 in the same cycle.
